// File: rtl/tuner_sweep_ctrl_pkg.sv
// Package shared by the tuner sweep controller files.
// - sweep_state_e : sweep FSM state encoding
// - MIN_PWR_FILL  : fill bit for the minimum-power tracker reset/start value
//                   (replicated to ADC_WIDTH, giving all-ones so any sample wins)
package tuner_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        UPDATE  = 3'd3,
        DONE    = 3'd4
    } sweep_state_e;

    localparam logic MIN_PWR_FILL = 1'b1;

endpackage

// File: rtl/tuner_sweep_ctrl_if.sv
// Power-detect handshake between the sweep controller and tuner_pwr_detect_phy.
// - pwr_detect_active  : controller is sweeping (SETTLE/MEASURE)
// - pwr_detect_refresh : one-cycle pulse when a new measurement window opens
// - pwr_detect_rdy     : controller accepts a sample this cycle
// - pwr_detect_val     : phy presents a sample
// - pwr_detect_data    : detected thru-port power
// master = controller side, slave = phy side.
interface tuner_sweep_ctrl_if #(
    parameter int ADC_WIDTH = 8
) ();
    logic                 pwr_detect_active;
    logic                 pwr_detect_refresh;
    logic                 pwr_detect_rdy;
    logic                 pwr_detect_val;
    logic [ADC_WIDTH-1:0] pwr_detect_data;

    modport master (
        output pwr_detect_active,
        output pwr_detect_refresh,
        output pwr_detect_rdy,
        input  pwr_detect_val,
        input  pwr_detect_data
    );

    modport slave (
        input  pwr_detect_active,
        input  pwr_detect_refresh,
        input  pwr_detect_rdy,
        output pwr_detect_val,
        output pwr_detect_data
    );
endinterface

// File: rtl/tuner_sweep_ctrl_settle_timer.sv
// Loadable down-counter with a zero flag.
// - i_clk/i_rst_n : clock, asynchronous active-low reset
// - i_load        : load i_load_val (takes priority over counting)
// - i_en          : decrement by one while non-zero
// - o_zero        : counter has reached zero
module tuner_settle_timer #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_load_val;
        end else if (i_en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign o_zero = (cnt_q == '0);
endmodule

// File: rtl/tuner_sweep_ctrl.sv
// Microring tuner wavelength sweep controller.
// Steps the DAC code from i_code_start by i_code_step (saturating), waits
// SETTLE_CYCLES after each code change, takes one power sample per step over
// the pd handshake, tracks the minimum (resonance dip) and parks the DAC there.
// Ports:
// - i_clk, i_rst_n              : clock, asynchronous active-low reset
// - i_start, i_abort            : begin sweep (when idle/done), stop to IDLE
// - i_code_start/step/num_steps : sweep config, sampled at start (0 step/num -> 1)
// - o_tune_code                 : DAC code
// - pd                          : power-detect handshake (master side)
// - o_busy, o_done              : sweeping, one-cycle done pulse
// - o_min_pwr, o_min_code       : sweep minimum and its code
module tuner_sweep_ctrl
    import tuner_ctrl_pkg::*;
#(
    parameter int ADC_WIDTH     = 8,
    parameter int DAC_WIDTH     = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [DAC_WIDTH-1:0] i_code_start,
    input  logic [DAC_WIDTH-1:0] i_code_step,
    input  logic [DAC_WIDTH-1:0] i_num_steps,
    output logic [DAC_WIDTH-1:0] o_tune_code,
    tuner_sweep_ctrl_if.master   pd,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [ADC_WIDTH-1:0] o_min_pwr,
    output logic [DAC_WIDTH-1:0] o_min_code
);
    // Timer holds SETTLE_CYCLES-1 so SETTLE lasts exactly SETTLE_CYCLES cycles.
    localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [ADC_WIDTH-1:0] MIN_PWR_INIT = {ADC_WIDTH{MIN_PWR_FILL}};

    sweep_state_e         state_q, state_d;
    logic [DAC_WIDTH-1:0] code_q, code_d;
    logic [DAC_WIDTH-1:0] cnt_q, cnt_d;
    logic [DAC_WIDTH-1:0] step_q, step_d;
    logic [DAC_WIDTH-1:0] num_q, num_d;
    logic [ADC_WIDTH-1:0] min_pwr_q, min_pwr_d;
    logic [DAC_WIDTH-1:0] min_code_q, min_code_d;
    logic                 refresh_q, done_q;
    logic [DAC_WIDTH:0]   step_sum;
    logic                 timer_load, timer_zero, fire;

    tuner_settle_timer #(.W(TW)) u_settle_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (timer_load),
        .i_load_val (SETTLE_LOAD),
        .i_en       (state_q == SETTLE),
        .o_zero     (timer_zero)
    );

    assign fire     = (state_q == MEASURE) && pd.pwr_detect_val;
    assign step_sum = {1'b0, code_q} + {1'b0, step_q};

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        num_d      = num_q;
        min_pwr_d  = min_pwr_q;
        min_code_d = min_code_q;
        timer_load = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    code_d     = i_code_start;
                    cnt_d      = '0;
                    step_d     = (i_code_step == '0) ? DAC_WIDTH'(1) : i_code_step;
                    num_d      = (i_num_steps == '0) ? DAC_WIDTH'(1) : i_num_steps;
                    min_pwr_d  = MIN_PWR_INIT;
                    min_code_d = i_code_start;
                    timer_load = 1'b1;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (timer_zero) state_d = MEASURE;
            end
            MEASURE: begin
                if (fire) begin
                    // Strict less-than: ties keep the earlier code.
                    if (pd.pwr_detect_data < min_pwr_q) begin
                        min_pwr_d  = pd.pwr_detect_data;
                        min_code_d = code_q;
                    end
                    cnt_d   = cnt_q + 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                if (cnt_q == num_q) begin
                    code_d  = min_code_q;
                    state_d = DONE;
                end else begin
                    code_d     = step_sum[DAC_WIDTH] ? '1 : step_sum[DAC_WIDTH-1:0];
                    timer_load = 1'b1;
                    state_d    = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides everything, including a same-cycle start.
        if (i_abort) begin
            state_d    = IDLE;
            code_d     = code_q;
            cnt_d      = cnt_q;
            step_d     = step_q;
            num_d      = num_q;
            min_pwr_d  = min_pwr_q;
            min_code_d = min_code_q;
            timer_load = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            code_q     <= '0;
            cnt_q      <= '0;
            step_q     <= '0;
            num_q      <= '0;
            min_pwr_q  <= MIN_PWR_INIT;
            min_code_q <= '0;
            refresh_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            num_q      <= num_d;
            min_pwr_q  <= min_pwr_d;
            min_code_q <= min_code_d;
            refresh_q  <= (state_d == MEASURE) && (state_q != MEASURE);
            done_q     <= (state_d == DONE) && (state_q != DONE);
        end
    end

    // Outputs
    always_comb begin
        pd.pwr_detect_rdy     = (state_q == MEASURE);
        pd.pwr_detect_active  = (state_q == SETTLE) || (state_q == MEASURE);
        pd.pwr_detect_refresh = refresh_q;
        o_busy                = (state_q != IDLE) && (state_q != DONE);
        o_done                = done_q;
        o_tune_code           = code_q;
        o_min_pwr             = min_pwr_q;
        o_min_code            = min_code_q;
    end
endmodule

// File: tb/tb_tuner_sweep_ctrl.sv
module tb_tuner_sweep_ctrl;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic [7:0] i_code_start = '0;
    logic [7:0] i_code_step = '0;
    logic [7:0] i_num_steps = '0;
    logic [7:0] o_tune_code, o_min_pwr, o_min_code;
    logic       o_busy, o_done;

    int checks = 0;
    int errors = 0;
    logic [7:0] pwr_tbl [16];
    logic [7:0] codes_seen [16];

    tuner_sweep_ctrl_if #(.ADC_WIDTH(8)) pd_if ();

    tuner_sweep_ctrl #(.ADC_WIDTH(8), .DAC_WIDTH(8), .SETTLE_CYCLES(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_code_start(i_code_start), .i_code_step(i_code_step), .i_num_steps(i_num_steps),
        .o_tune_code(o_tune_code), .pd(pd_if.master), .o_busy(o_busy), .o_done(o_done),
        .o_min_pwr(o_min_pwr), .o_min_code(o_min_code)
    );

    always #5 i_clk = ~i_clk;

    task automatic start_sweep(input logic [7:0] cs, input logic [7:0] st, input logic [7:0] ns);
        @(negedge i_clk);
        i_code_start = cs; i_code_step = st; i_num_steps = ns; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Answers n MEASURE windows with pwr_tbl[], logging the code seen at each.
    task automatic serve(input int n, output int got);
        int t;
        got = 0;
        for (int k = 0; k < n; k++) begin
            t = 0;
            @(negedge i_clk);
            while (!pd_if.pwr_detect_rdy && t < 100) begin
                @(negedge i_clk);
                t++;
            end
            if (!pd_if.pwr_detect_rdy) return;
            codes_seen[k] = o_tune_code;
            pd_if.pwr_detect_val = 1'b1;
            pd_if.pwr_detect_data = pwr_tbl[k];
            @(negedge i_clk);
            pd_if.pwr_detect_val = 1'b0;
            got++;
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge i_clk);
            if (o_done) n++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge i_clk);
        checks++; if (o_tune_code !== 8'd0) begin errors++; $display("FAIL reset_code got %0d want 0", o_tune_code); end
        checks++; if (o_min_pwr !== 8'hFF) begin errors++; $display("FAIL reset_min_pwr got %0d want 255", o_min_pwr); end
        checks++; if (o_min_code !== 8'd0) begin errors++; $display("FAIL reset_min_code got %0d want 0", o_min_code); end
        checks++; if ({o_busy, o_done, pd_if.pwr_detect_rdy, pd_if.pwr_detect_active, pd_if.pwr_detect_refresh} !== 5'b0)
            begin errors++; $display("FAIL reset_flags got %b want 00000", {o_busy, o_done, pd_if.pwr_detect_rdy, pd_if.pwr_detect_active, pd_if.pwr_detect_refresh}); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_flat_ramp;
        int got, nd;
        logic [7:0] exp_codes [4];
        exp_codes = '{8'd10, 8'd15, 8'd20, 8'd25};
        for (int k = 0; k < 4; k++) pwr_tbl[k] = 8'd200;
        start_sweep(8'd10, 8'd5, 8'd4);
        serve(4, got);
        checks++; if (got !== 4) begin errors++; $display("FAIL flat_samples got %0d want 4", got); end
        for (int k = 0; k < got; k++) begin
            checks++; if (codes_seen[k] !== exp_codes[k]) begin errors++; $display("FAIL flat_code%0d got %0d want %0d", k, codes_seen[k], exp_codes[k]); end
        end
        count_done(10, nd);
        checks++; if (nd !== 1) begin errors++; $display("FAIL flat_done_pulses got %0d want 1", nd); end
        checks++; if (o_min_pwr !== 8'd200) begin errors++; $display("FAIL flat_min_pwr got %0d want 200", o_min_pwr); end
        checks++; if (o_min_code !== 8'd10) begin errors++; $display("FAIL flat_min_code got %0d want 10", o_min_code); end
        checks++; if (o_tune_code !== 8'd10) begin errors++; $display("FAIL flat_park_code got %0d want 10", o_tune_code); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL flat_busy got %0d want 0", o_busy); end
    endtask

    task automatic test_dip;
        int got, nd;
        pwr_tbl[0] = 8'd180; pwr_tbl[1] = 8'd40; pwr_tbl[2] = 8'd90;
        start_sweep(8'd0, 8'd8, 8'd3);
        serve(3, got);
        checks++; if (got !== 3) begin errors++; $display("FAIL dip_samples got %0d want 3", got); end
        checks++; if (codes_seen[2] !== 8'd16) begin errors++; $display("FAIL dip_code2 got %0d want 16", codes_seen[2]); end
        count_done(10, nd);
        checks++; if (nd !== 1) begin errors++; $display("FAIL dip_done_pulses got %0d want 1", nd); end
        checks++; if (o_min_pwr !== 8'd40) begin errors++; $display("FAIL dip_min_pwr got %0d want 40", o_min_pwr); end
        checks++; if (o_min_code !== 8'd8) begin errors++; $display("FAIL dip_min_code got %0d want 8", o_min_code); end
        checks++; if (o_tune_code !== 8'd8) begin errors++; $display("FAIL dip_park_code got %0d want 8", o_tune_code); end
    endtask

    task automatic test_saturation;
        int got, nd;
        logic [7:0] exp_codes [4];
        exp_codes = '{8'd250, 8'd254, 8'd255, 8'd255};
        pwr_tbl[0] = 8'd100; pwr_tbl[1] = 8'd90; pwr_tbl[2] = 8'd90; pwr_tbl[3] = 8'd120;
        start_sweep(8'd250, 8'd4, 8'd4);
        serve(4, got);
        checks++; if (got !== 4) begin errors++; $display("FAIL sat_samples got %0d want 4", got); end
        for (int k = 0; k < got; k++) begin
            checks++; if (codes_seen[k] !== exp_codes[k]) begin errors++; $display("FAIL sat_code%0d got %0d want %0d", k, codes_seen[k], exp_codes[k]); end
        end
        count_done(10, nd);
        checks++; if (o_min_code !== 8'd254) begin errors++; $display("FAIL sat_min_code got %0d want 254", o_min_code); end
        checks++; if (o_tune_code !== 8'd254) begin errors++; $display("FAIL sat_park_code got %0d want 254", o_tune_code); end
    endtask

    task automatic test_handshake_timing;
        int first_rdy, refresh_cnt, refresh_at_first, rdy_total, rdy_outside, stall, fires, dones;
        first_rdy = -1; refresh_cnt = 0; refresh_at_first = 0; rdy_total = 0;
        rdy_outside = 0; stall = 0; fires = 0; dones = 0;
        start_sweep(8'd0, 8'd1, 8'd2);
        for (int c = 1; c <= 200 && dones == 0; c++) begin
            @(negedge i_clk);
            pd_if.pwr_detect_val = 1'b0;
            if (pd_if.pwr_detect_refresh) refresh_cnt++;
            if (o_done) dones++;
            if (pd_if.pwr_detect_rdy && !pd_if.pwr_detect_active) rdy_outside++;
            if (c == 1) begin
                // Sample presented while not ready: must be dropped.
                pd_if.pwr_detect_val = 1'b1;
                pd_if.pwr_detect_data = 8'd5;
            end
            if (pd_if.pwr_detect_rdy) begin
                rdy_total++;
                if (first_rdy < 0) begin
                    first_rdy = c;
                    refresh_at_first = int'(pd_if.pwr_detect_refresh);
                end
                if (fires == 0 && stall < 10) begin
                    stall++;
                end else begin
                    pd_if.pwr_detect_val = 1'b1;
                    pd_if.pwr_detect_data = (fires == 0) ? 8'd50 : 8'd60;
                    fires++;
                end
            end
        end
        pd_if.pwr_detect_val = 1'b0;
        checks++; if (first_rdy !== 4) begin errors++; $display("FAIL hs_first_rdy_cycle got %0d want 4", first_rdy); end
        checks++; if (refresh_at_first !== 1) begin errors++; $display("FAIL hs_refresh_on_entry got %0d want 1", refresh_at_first); end
        checks++; if (rdy_total !== 12) begin errors++; $display("FAIL hs_rdy_cycles got %0d want 12", rdy_total); end
        checks++; if (refresh_cnt !== 2) begin errors++; $display("FAIL hs_refresh_pulses got %0d want 2", refresh_cnt); end
        checks++; if (rdy_outside !== 0) begin errors++; $display("FAIL hs_rdy_outside got %0d want 0", rdy_outside); end
        checks++; if (dones !== 1) begin errors++; $display("FAIL hs_done got %0d want 1", dones); end
        checks++; if (o_min_pwr !== 8'd50) begin errors++; $display("FAIL hs_min_pwr got %0d want 50", o_min_pwr); end
    endtask

    task automatic test_start_ignored;
        int got, nd;
        pwr_tbl[0] = 8'd10; pwr_tbl[1] = 8'd20; pwr_tbl[2] = 8'd5;
        start_sweep(8'd100, 8'd2, 8'd2);
        // Busy now: a second start with different config must change nothing.
        start_sweep(8'd7, 8'd9, 8'd5);
        serve(2, got);
        checks++; if (got !== 2) begin errors++; $display("FAIL ign_samples got %0d want 2", got); end
        checks++; if (codes_seen[0] !== 8'd100 || codes_seen[1] !== 8'd102)
            begin errors++; $display("FAIL ign_codes got %0d,%0d want 100,102", codes_seen[0], codes_seen[1]); end
        count_done(10, nd);
        checks++; if (nd !== 1) begin errors++; $display("FAIL ign_done got %0d want 1", nd); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ign_busy_after got %0d want 0", o_busy); end
        checks++; if (o_min_code !== 8'd100) begin errors++; $display("FAIL ign_min_code got %0d want 100", o_min_code); end
    endtask

    task automatic test_abort;
        int nd;
        start_sweep(8'd30, 8'd1, 8'd3);
        @(negedge i_clk);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        checks++; if ({o_busy, pd_if.pwr_detect_active} !== 2'b00) begin errors++; $display("FAIL abort_busy_active got %b want 00", {o_busy, pd_if.pwr_detect_active}); end
        checks++; if (o_tune_code !== 8'd30) begin errors++; $display("FAIL abort_code_kept got %0d want 30", o_tune_code); end
        checks++; if (o_min_pwr !== 8'hFF || o_min_code !== 8'd30)
            begin errors++; $display("FAIL abort_min_kept got %0d/%0d want 255/30", o_min_pwr, o_min_code); end
        count_done(10, nd);
        checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", nd); end
        @(negedge i_clk);
        i_code_start = 8'd77; i_start = 1'b1; i_abort = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0; i_abort = 1'b0;
        checks++; if (o_busy !== 1'b0 || o_tune_code !== 8'd30)
            begin errors++; $display("FAIL abort_wins_start got busy=%0d code=%0d want 0/30", o_busy, o_tune_code); end
    endtask

    task automatic test_async_reset;
        int got, nd, t;
        start_sweep(8'd40, 8'd1, 8'd2);
        t = 0;
        while (!pd_if.pwr_detect_rdy && t < 100) begin @(negedge i_clk); t++; end
        checks++; if (pd_if.pwr_detect_rdy !== 1'b1) begin errors++; $display("FAIL arst_reach_measure got %0d want 1", pd_if.pwr_detect_rdy); end
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if ({o_busy, pd_if.pwr_detect_rdy, pd_if.pwr_detect_active} !== 3'b000)
            begin errors++; $display("FAIL arst_flags got %b want 000", {o_busy, pd_if.pwr_detect_rdy, pd_if.pwr_detect_active}); end
        checks++; if (o_tune_code !== 8'd0 || o_min_pwr !== 8'hFF || o_min_code !== 8'd0)
            begin errors++; $display("FAIL arst_values got %0d/%0d/%0d want 0/255/0", o_tune_code, o_min_pwr, o_min_code); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        // Zero step and zero count both behave as one.
        pwr_tbl[0] = 8'd77;
        start_sweep(8'd3, 8'd0, 8'd0);
        serve(1, got);
        count_done(10, nd);
        checks++; if (got !== 1 || nd !== 1) begin errors++; $display("FAIL arst_restart got samples=%0d done=%0d want 1/1", got, nd); end
        checks++; if (o_min_pwr !== 8'd77 || o_min_code !== 8'd3 || o_tune_code !== 8'd3)
            begin errors++; $display("FAIL arst_restart_min got %0d/%0d/%0d want 77/3/3", o_min_pwr, o_min_code, o_tune_code); end
    endtask

    initial begin
        pd_if.pwr_detect_val = 1'b0;
        pd_if.pwr_detect_data = '0;
        test_reset();
        test_flat_ramp();
        test_dip();
        test_saturation();
        test_handshake_timing();
        test_start_ignored();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
